// File: rtl/div6x3_seq.sv
// Sequential restoring divider (DIVIDEND_W / DIVISOR_W), one quotient bit per clock.
// Optional macro DIV_SELFCHECK_EN adds a sticky reconstruction check on check_err.
module div6x3_seq #(
   parameter int unsigned DIVIDEND_W = 6,
   parameter int unsigned DIVISOR_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  check_err
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state;
   logic [DIVIDEND_W-1:0] dvd_sh;
   logic [DIVIDEND_W-2:0] q_sh;
   logic [DIVISOR_W-1:0]  dvs;
   logic [DIVISOR_W-1:0]  p_r;
   logic [CNT_W-1:0]      cnt;

   logic [DIVISOR_W:0]    p_shift;
   logic                  ge;
   logic [DIVISOR_W-1:0]  p_next;
   logic [DIVIDEND_W-1:0] q_next;

   // One restoring step; the kept remainder always fits DIVISOR_W bits since it is < divisor.
   always_comb begin
      p_shift = {p_r, dvd_sh[DIVIDEND_W-1]};
      ge      = (p_shift >= {1'b0, dvs});
      p_next  = ge ? DIVISOR_W'(p_shift - {1'b0, dvs}) : p_shift[DIVISOR_W-1:0];
      q_next  = {q_sh, ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         dvd_sh      <= '0;
         q_sh        <= '0;
         dvs         <= '0;
         p_r         <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  dvd_sh      <= dividend;
                  dvs         <= divisor;
                  p_r         <= '0;
                  q_sh        <= '0;
                  busy        <= 1'b1;
                  div_by_zero <= (divisor == '0);
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= '0;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     cnt   <= CNT_W'(DIVIDEND_W);
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], 1'b0};
               p_r    <= p_next;
               q_sh   <= q_next[DIVIDEND_W-2:0];
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  quotient  <= q_next;
                  remainder <= p_next;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DIV_SELFCHECK_EN
   localparam int unsigned PROD_W = DIVIDEND_W + DIVISOR_W + 1;

   logic [DIVIDEND_W-1:0] dvd_lat;
   logic [PROD_W-1:0]     recon;

   always_comb recon = PROD_W'(quotient) * PROD_W'(dvs) + PROD_W'(remainder);

   // Sticky flag: results must reconstruct the accepted dividend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_lat   <= '0;
         check_err <= 1'b0;
      end else begin
         if (state == S_IDLE && start)
            dvd_lat <= dividend;
         if (state == S_DONE && !div_by_zero && recon != PROD_W'(dvd_lat))
            check_err <= 1'b1;
      end
   end
`else
   assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_div6x3_seq.sv
// Scoreboard bench for div6x3_seq: directed cases, reset abort and a full operand sweep.
module tb_div6x3_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] dividend;
   logic [2:0] divisor;
   logic       busy;
   logic       done;
   logic [5:0] quotient;
   logic [2:0] remainder;
   logic       div_by_zero;
   logic       check_err;

   div6x3_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .check_err   (check_err)
   );

   typedef struct {
      int q;
      int r;
      int dz;
      int lat;
      int acc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("quotient",    32'(quotient),    32'(e.q));
            chk("remainder",   32'(remainder),   32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            chk("latency",     32'(cyc - e.acc + 1), 32'(e.lat));
            chk("busy_at_done", 32'(busy), 32'd1);
            chk("check_err",   32'(check_err),   32'd0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=1 expected 0 within 40 cycles");
      end
   endtask

   // Issue one operation; hold>0 keeps start high (with scrambled operands) for that many edges.
   task automatic do_op(input int a, input int b, input int eq, input int er, input int edz,
                        input int hold);
      exp_t e;
      wait_idle();
      start    = 1'b1;
      dividend = 6'(a);
      divisor  = 3'(b);
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      e.lat = edz ? 1 : 7;
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      if (hold > 0) begin
         dividend = 6'd63;
         divisor  = 3'd1;
         repeat (hold) @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy",      32'(busy),        32'd0);
      chk("rst_done",      32'(done),        32'd0);
      chk("rst_quotient",  32'(quotient),    32'd0);
      chk("rst_remainder", 32'(remainder),   32'd0);
      chk("rst_dz",        32'(div_by_zero), 32'd0);
      chk("rst_check_err", 32'(check_err),   32'd0);
      rst_n = 1'b1;

      do_op(45, 5, 9, 0, 0, 0);
      do_op(50, 3, 16, 2, 0, 0);
      do_op(63, 7, 9, 0, 0, 0);
      do_op(6, 7, 0, 6, 0, 0);
      do_op(7, 0, 63, 0, 1, 0);
      do_op(12, 4, 3, 0, 0, 0);
      do_op(20, 3, 6, 2, 0, 7);

      // Abort 60/7 three cycles after accept; no done may follow.
      wait_idle();
      start    = 1'b1;
      dividend = 6'd60;
      divisor  = 3'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy",      32'(busy),        32'd0);
      chk("abort_done",      32'(done),        32'd0);
      chk("abort_quotient",  32'(quotient),    32'd0);
      chk("abort_remainder", 32'(remainder),   32'd0);
      chk("abort_dz",        32'(div_by_zero), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      do_op(60, 7, 8, 4, 0, 0);

      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 8; b++) begin
            if (b == 0) do_op(a, b, 63, 0, 1, 0);
            else        do_op(a, b, a / b, a % b, 0, 0);
         end
      end

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("pending_results", 32'(exp_q.size()), 32'd0);
      chk("final_check_err", 32'(check_err),    32'd0);
      chk("final_busy",      32'(busy),         32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
